// File: rtl/rgb2gray_stage.sv
// rgb2gray_stage: two-stage RGB to gray luma pipeline feeding a gray FIFO.
// Optional GRAY_ROUND_EN: round-to-nearest with saturation, else truncation.
module rgb2gray_stage #(
  parameter int DATA_WIDTH   = 8,
  parameter int KR           = 77,
  parameter int KG           = 150,
  parameter int KB           = 29,
  parameter int FRAME_PIXELS = 16,
  parameter int CNT_WIDTH    = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [3*DATA_WIDTH-1:0]   in_rgb,
  output logic                      fifo_wr,
  output logic [DATA_WIDTH-1:0]     fifo_data,
  input  logic                      fifo_full,
  output logic                      frame_done
);
  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [PW-1:0] KR_W = PW'(KR);
  localparam logic [PW-1:0] KG_W = PW'(KG);
  localparam logic [PW-1:0] KB_W = PW'(KB);
  localparam logic [CNT_WIDTH-1:0] LAST =
    CNT_WIDTH'(FRAME_PIXELS - 1);

  logic                  s1_valid;
  logic                  s2_valid;
  logic [PW-1:0]         s1_pr;
  logic [PW-1:0]         s1_pg;
  logic [PW-1:0]         s1_pb;
  logic [PW-1:0]         sum;
  logic [PW-1:0]         r_ext;
  logic [PW-1:0]         g_ext;
  logic [PW-1:0]         b_ext;
  logic [DATA_WIDTH-1:0] gray;
  logic [CNT_WIDTH-1:0]  pix_cnt;
  logic                  stall;
  logic                  advance;

  assign r_ext = {{DATA_WIDTH{1'b0}},
                  in_rgb[3*DATA_WIDTH-1:2*DATA_WIDTH]};
  assign g_ext = {{DATA_WIDTH{1'b0}},
                  in_rgb[2*DATA_WIDTH-1:DATA_WIDTH]};
  assign b_ext = {{DATA_WIDTH{1'b0}},
                  in_rgb[DATA_WIDTH-1:0]};

  // Only a valid S2 pixel blocked by a full FIFO freezes the pipe;
  // bubbles keep flowing so up to two pixels are absorbed.
  assign stall    = s2_valid & fifo_full;
  assign advance  = ~stall;
  assign in_ready = rstn & advance;
  assign fifo_wr  = rstn & s2_valid & ~fifo_full;

  // Coefficients sum to 256, so the 16-bit sum never overflows.
  assign sum = s1_pr + s1_pg + s1_pb;

`ifdef GRAY_ROUND_EN
  localparam int PW1 = PW + 1;
  localparam logic [PW:0] HALF = PW1'(2 ** (DATA_WIDTH - 1));
  logic [PW:0]         sum_r;
  logic [DATA_WIDTH:0] rnd;
  assign sum_r = {1'b0, sum} + HALF;
  assign rnd   = sum_r[PW:DATA_WIDTH];
  assign gray  = rnd[DATA_WIDTH] ? '1 : rnd[DATA_WIDTH-1:0];
`else
  assign gray  = sum[PW-1:DATA_WIDTH];
`endif

  // Pipeline registers: S1 holds products, S2 holds the gray pixel.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      fifo_data <= '0;
    end else if (advance) begin
      s1_valid  <= in_valid;
      s1_pr     <= r_ext * KR_W;
      s1_pg     <= g_ext * KG_W;
      s1_pb     <= b_ext * KB_W;
      s2_valid  <= s1_valid;
      fifo_data <= gray;
    end
  end

  // Frame pixel counter; frame_done follows the last write by one cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pix_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (fifo_wr) begin
        if (pix_cnt == LAST) begin
          pix_cnt    <= '0;
          frame_done <= 1'b1;
        end else begin
          pix_cnt <= pix_cnt + CNT_WIDTH'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_rgb2gray_stage.sv
// tb_rgb2gray_stage: directed checks of rgb2gray_stage against
// a queue-based luma model, frame counting and full backpressure.
module tb_rgb2gray_stage;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        fifo_full = 1'b0;
  logic [23:0] in_rgb = '0;
  logic        in_ready;
  logic        fifo_wr;
  logic        frame_done;
  logic [7:0]  fifo_data;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int frm = 0;
  bit fd_exp = 1'b0;
  int fd_seen = 0;
  int run = 0;
  int max_run = 0;
  int q[$];
  int acc_q[$];
  int wr_log[$];
  int lat_log[$];
  logic [7:0] held;

  always #5 clk = ~clk;

  rgb2gray_stage dut (
    .clk(clk),
    .rstn(rstn),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_rgb(in_rgb),
    .fifo_wr(fifo_wr),
    .fifo_data(fifo_data),
    .fifo_full(fifo_full),
    .frame_done(frame_done)
  );

  function automatic int gray_of(input int r, input int g,
                                 input int b);
    int s;
    s = r * 77 + g * 150 + b * 29;
`ifdef GRAY_ROUND_EN
    s = (s + 128) / 256;
    if (s > 255) s = 255;
`else
    s = s / 256;
`endif
    return s;
  endfunction

  task automatic chk(input string nm, input int act,
                     input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Model and compare process, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    chk("frame_done", int'(frame_done), int'(fd_exp));
    fd_exp = 1'b0;
    if (frame_done) fd_seen++;
    if (!rstn) begin
      chk("rst_wr", int'(fifo_wr), 0);
      chk("rst_ready", int'(in_ready), 0);
      q.delete();
      acc_q.delete();
      frm = 0;
      run = 0;
    end else begin
      if (fifo_wr) begin
        run++;
        if (run > max_run) max_run = run;
        wr_log.push_back(int'(fifo_data));
        if (q.size() == 0) begin
          chk("spurious_wr", 1, 0);
        end else begin
          chk("wr_data", int'(fifo_data), q.pop_front());
          lat_log.push_back(cyc - acc_q.pop_front());
        end
        frm++;
        if (frm == 16) begin
          frm = 0;
          fd_exp = 1'b1;
        end
      end else begin
        run = 0;
      end
      if (in_valid && in_ready) begin
        q.push_back(gray_of(int'(in_rgb[23:16]),
                            int'(in_rgb[15:8]),
                            int'(in_rgb[7:0])));
        acc_q.push_back(cyc);
      end
    end
  end

  task automatic send(input int r, input int g, input int b);
    in_valid = 1'b1;
    in_rgb = {r[7:0], g[7:0], b[7:0]};
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    chk("send_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (q.size() == 0) break;
    end
    chk("drain_left", q.size(), 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rstn = 1'b0;
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic clear_logs();
    wr_log.delete();
    lat_log.delete();
    fd_seen = 0;
    max_run = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_data", int'(fifo_data), 0);
    chk("rst_fd", int'(frame_done), 0);
    chk("rst_cnt", int'(dut.pix_cnt), 0);
    chk("idle_wr", int'(fifo_wr), 0);
    chk("idle_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;

    clear_logs();
    send(255, 255, 255);
    send(0, 0, 0);
    send(100, 50, 200);
    drain(20);
    chk("t1_count", wr_log.size(), 3);
    if (wr_log.size() == 3) begin
      chk("t1_white", wr_log[0], 255);
      chk("t1_black", wr_log[1], 0);
      chk("t1_mix", wr_log[2], 82);
      chk("t1_lat", lat_log[0], 2);
    end

    clear_logs();
    send(0, 0, 255);
    drain(20);
    chk("t2_count", wr_log.size(), 1);
    if (wr_log.size() == 1) begin
`ifdef GRAY_ROUND_EN
      chk("t2_blue", wr_log[0], 29);
`else
      chk("t2_blue", wr_log[0], 28);
`endif
    end

    clear_logs();
    for (int i = 0; i < 10; i++)
      send(i * 20, 255 - i * 10, i * 7 + 3);
    drain(20);
    chk("t3_count", wr_log.size(), 10);
    chk("t3_run", max_run, 10);

    clear_logs();
    fifo_full = 1'b1;
    send(10, 200, 30);
    send(250, 5, 90);
    in_valid = 1'b1;
    in_rgb = {8'd60, 8'd120, 8'd180};
    @(negedge clk);
    held = fifo_data;
    for (int i = 0; i < 5; i++) begin
      chk("t4_wr", int'(fifo_wr), 0);
      chk("t4_ready", int'(in_ready), 0);
      chk("t4_hold", int'(fifo_data), int'(held));
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    fifo_full = 1'b0;
    send(60, 120, 180);
    drain(20);
    chk("t4_count", wr_log.size(), 3);
    if (wr_log.size() == 3) begin
      chk("t4_first", wr_log[0], gray_of(10, 200, 30));
      chk("t4_last", wr_log[2], gray_of(60, 120, 180));
    end

    do_reset(2);
    clear_logs();
    for (int i = 0; i < 33; i++)
      send(i * 7, i * 3, 255 - i * 5);
    drain(20);
    chk("t5_count", wr_log.size(), 33);
    chk("t5_frames", fd_seen, 2);
    chk("t5_cnt", int'(dut.pix_cnt), 1);

    do_reset(2);
    clear_logs();
    for (int i = 0; i < 5; i++)
      send(i * 40, 100, 200 - i * 30);
    do_reset(3);
    clear_logs();
    for (int i = 0; i < 16; i++)
      send(i * 15, 255 - i * 15, 128);
    drain(20);
    chk("t6_count", wr_log.size(), 16);
    chk("t6_frames", fd_seen, 1);
    chk("t6_cnt", int'(dut.pix_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
